// File: rtl/lr_pkg.sv
// Shared fixed-point constants, FSM states and sizing helpers
// for the linear-regression inference block (lr_predictor).
package lr_pkg;

  localparam int DW   = 16;
  localparam int FRAC = 10;

  localparam logic [DW-1:0] FX_ONE  = 16'h0400;
  localparam logic [DW-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DW-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  // Wide enough to sum n full-width products without overflow.
  function automatic int acc_w(input int n);
    return 2 * DW + $clog2(n);
  endfunction

endpackage

// File: rtl/lr_mac_unit.sv
// Signed multiply-accumulate with clear/enable and a
// round-half-up, saturating Q5.10 output stage.
module lr_mac_unit
  import lr_pkg::*;
#(
  parameter int AW = 34
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [AW-1:0] clr_val,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic        [DW-1:0] y_nxt,
  output logic                 sat_nxt
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_nxt;
  logic signed [AW-1:0]   rnd;
  logic signed [AW-1:0]   r;
  logic                   ovf;

  assign prod    = a * b;
  assign acc_nxt = acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= clr_val;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

  // Output stage sees the sum including the product in flight,
  // so the result can be registered on the last MAC edge.
  assign rnd = acc_nxt + $signed(AW'(1 << (FRAC - 1)));
  assign r   = rnd >>> FRAC;

  assign ovf = (r[AW-1:DW-1] != '0) &&
               (r[AW-1:DW-1] != '1);

  assign sat_nxt = ovf;
  assign y_nxt   = !ovf      ? r[DW-1:0] :
                   r[AW-1]   ? SAT_MIN   : SAT_MAX;

endmodule

// File: rtl/lr_predictor.sv
// Sequential-MAC linear-regression predictor: y = sum(x*w) (+ b).
// Optional bias register enabled by defining LR_BIAS_EN.
module lr_predictor
  import lr_pkg::*;
#(
  parameter int N_FEAT = 4
`ifdef LR_BIAS_EN
  , localparam int AW = $clog2(N_FEAT + 1)
`else
  , localparam int AW = $clog2(N_FEAT)
`endif
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   wt_we,
  input  logic [AW-1:0]          wt_addr,
  input  logic [DW-1:0]          wt_data,
  output logic                   wt_ready,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_FEAT*DW-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_y,
  output logic                   out_sat
);

  localparam int IW   = $clog2(N_FEAT);
  localparam int ACCW = acc_w(N_FEAT);

  state_t state;
  state_t state_nxt;

  logic [IW-1:0]          idx;
  logic signed [DW-1:0]   w [N_FEAT];
  logic [N_FEAT*DW-1:0]   x_q;
  logic signed [DW-1:0]   x_cur;
  logic signed [ACCW-1:0] acc_init;
  logic [DW-1:0]          y_nxt;
  logic                   sat_nxt;
  logic                   accept;
  logic                   last;
  logic                   mac_en;
  logic                   wt_ok;

  assign in_ready  = (state == IDLE);
  assign wt_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign accept = in_valid && in_ready;
  assign mac_en = (state == MAC);
  assign last   = mac_en && (idx == IW'(N_FEAT - 1));
  assign wt_ok  = wt_we && wt_ready &&
                  (32'(wt_addr) < N_FEAT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = MAC;
      MAC:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_FEAT; i++) begin
        w[i] <= '0;
      end
    end else if (wt_ok) begin
      w[wt_addr[IW-1:0]] <= wt_data;
    end
  end

`ifdef LR_BIAS_EN
  logic signed [DW-1:0] bias;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bias <= '0;
    end else if (wt_we && wt_ready &&
                 32'(wt_addr) == N_FEAT) begin
      bias <= wt_data;
    end
  end

  assign acc_init = {{(ACCW-DW-FRAC){bias[DW-1]}},
                     bias, {FRAC{1'b0}}};
`else
  assign acc_init = '0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_q <= '0;
      idx <= '0;
    end else if (accept) begin
      x_q <= in_data;
      idx <= '0;
    end else if (mac_en) begin
      idx <= idx + 1'b1;
    end
  end

  assign x_cur = x_q[int'(idx)*DW +: DW];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_y   <= '0;
      out_sat <= 1'b0;
    end else if (last) begin
      out_y   <= y_nxt;
      out_sat <= sat_nxt;
    end
  end

  lr_mac_unit #(
    .AW (ACCW)
  ) u_mac (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (accept),
    .en      (mac_en),
    .clr_val (acc_init),
    .a       (x_cur),
    .b       (w[idx]),
    .y_nxt   (y_nxt),
    .sat_nxt (sat_nxt)
  );

endmodule

// File: tb/tb_lr_predictor.sv
// Scoreboard bench for lr_predictor: directed vectors push expected
// results; a negedge monitor pops and compares on each output handshake.
module tb_lr_predictor;
  import lr_pkg::*;

  localparam int N = 4;
`ifdef LR_BIAS_EN
  localparam int AW = 3;
`else
  localparam int AW = 2;
`endif

  typedef struct packed {
    logic [15:0] y;
    logic        sat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wt_we;
  logic [AW-1:0]   wt_addr;
  logic [15:0]     wt_data;
  logic            wt_ready;
  logic            in_valid;
  logic            in_ready;
  logic [N*16-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_y;
  logic            out_sat;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  lr_predictor #(.N_FEAT(N)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .wt_we     (wt_we),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data),
    .wt_ready  (wt_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_sat   (out_sat)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h want none", out_y);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_y", 32'(out_y), 32'(e.y));
        chk("out_sat", 32'(out_sat), 32'(e.sat));
      end
    end
  end

  function automatic logic [N*16-1:0] pack(
    input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    wt_we   = 1'b1;
    wt_addr = AW'(a);
    wt_data = d;
    @(posedge clk); #1;
    wt_we   = 1'b0;
  endtask

  task automatic wr_all(input logic [15:0] d);
    for (int i = 0; i < N; i++) wr(i, d);
  endtask

  task automatic send(input logic [N*16-1:0] v,
                      input logic [15:0] ey, input logic es,
                      input bit wait_lat);
    int n;
    int lat;
    exp_t e;
    in_data  = v;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.y   = ey;
    e.sat = es;
    q.push_back(e);
    #1;
    in_valid = 1'b0;
    if (wait_lat) begin
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("latency", 32'(lat), 32'(N));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  logic [N*16-1:0] basic;
  logic [15:0]     hold;

  initial begin
    rst_n     = 1'b0;
    wt_we     = 1'b0;
    wt_addr   = '0;
    wt_data   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    basic     = pack(16'h0800, 16'h1000, 16'h0C00, 16'h1800);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wt_ready", 32'(wt_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0.25 * (2 + 4 + 3 + 6) = 3.75
    wr_all(16'h0100);
    send(basic, 16'h0F00, 1'b0, 1'b1);
    drain();

    // -1.0 * 0x0801 rounds half up to 0xF7FF
    wr(0, 16'hFC00);
    wr(1, 16'h0000);
    wr(2, 16'h0000);
    wr(3, 16'h0000);
    send(pack(16'h0801, 16'h1234, 16'h7FFF, 16'h8000),
         16'hF7FF, 1'b0, 1'b1);
    drain();

    wr_all(16'h7FFF);
    send(pack(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF),
         SAT_MAX, 1'b1, 1'b1);
    drain();
    wr_all(16'h8000);
    send(pack(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF),
         SAT_MIN, 1'b1, 1'b1);
    drain();

    // Write attempted during MAC must be dropped
    wr_all(16'h0100);
    send(basic, 16'h0F00, 1'b0, 1'b0);
    chk("wt_ready_mac", 32'(wt_ready), 32'd0);
    wr(0, 16'h7FFF);
    drain();
    send(basic, 16'h0F00, 1'b0, 1'b1);
    drain();

    // Backpressure in DONE
    out_ready = 1'b0;
    send(basic, 16'h0F00, 1'b0, 1'b1);
    hold = out_y;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = pack(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      @(posedge clk); #1;
      chk("bp_hold_y", 32'(out_y), 32'(hold));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

`ifdef LR_BIAS_EN
    wr(N, FX_ONE);
    send(basic, 16'h1300, 1'b0, 1'b1);
    drain();
`endif

    // Reset mid-MAC discards result and clears weights
    send(basic, 16'h0F00, 1'b0, 1'b0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(basic, 16'h0000, 1'b0, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
